xor_parity_scheduler: RTL and testbench
=======================================

// Module: xor_parity_scheduler
// PURPOSE
// Round-robin scheduler that shares one external 2-input XOR cell between NREQ requesters.
// Each granted word is folded bit-serially through the shared cell to produce its even-parity bit.
// Sits beside a single xor2 instance in parity/CRC glue logic, where area matters more than throughput.
// The scheduler drives the cell's A1/A2 pins and samples its Z pin.
// PARAMETERS
// NREQ   4   number of requesters (2..8)
// WIDTH  8   data bits per requester word (2..32)
// IDW    2   width of requester index; must satisfy 2**IDW >= NREQ
// PORTS
// CLK      input   1           rising-edge clock, single clock domain
// RST      input   1           synchronous, active-high reset
// REQ      input   NREQ        REQ[i]=1: requester i has a word pending
// DATA     input   NREQ*WIDTH  word of requester i on DATA[i*WIDTH +: WIDTH]
// ACK      output  NREQ        one-cycle pulse: word of requester i captured
// BUSY     output  1           1 while a word is being folded or reported
// PAR      output  1           parity result, valid only when PAR_VLD=1
// PAR_VLD  output  1           one-cycle result strobe
// PAR_ID   output  IDW         index of the requester owning PAR
// XOR_A1   output  1           to shared xor2 A1 pin (accumulator)
// XOR_A2   output  1           to shared xor2 A2 pin (current data bit)
// XOR_Z    input   1           from shared xor2 Z pin (A1^A2, combinational)
// VDD, VSS inout   1           supply pins, no logical function
// BEHAVIOUR
// - Reset (RST=1 at a CLK edge):
//   - state=IDLE, ptr=0.
//   - ACK, BUSY, PAR, PAR_VLD, PAR_ID, XOR_A1, XOR_A2 all 0.
//   - shift reg, acc and cnt cleared.
// - Reset mid-operation: the word in flight is aborted; no PAR_VLD is issued and it is not re-acked.
// - State machine: IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE, REQ==0: stay in IDLE.
// - IDLE, REQ!=0, at the edge:
//   - winner w = first set REQ bit searching ptr, ptr+1, ... mod NREQ.
//   - sreg<=DATA[w], acc<=0, cnt<=0, id<=w, ptr<=(w+1) mod NREQ, ACK[w]<=1; go to SHIFT.
// - SHIFT:
//   - XOR_A1=acc, XOR_A2=sreg[0].
//   - Each edge: acc<=XOR_Z, sreg<=sreg>>1, cnt<=cnt+1.
//   - When cnt==WIDTH-1, go to DONE.
// - DONE: for one cycle, PAR=acc, PAR_VLD=1, PAR_ID=id; then go to IDLE.
// - XOR_A1/XOR_A2 are 0 outside SHIFT; XOR_Z is ignored outside SHIFT.
// - ACK is registered; it is high exactly in the first SHIFT cycle, one-hot, and never in two cycles for one capture.
// - Timing from the grant edge: grant edge at cycle T, ACK at T+1, PAR_VLD at T+1+WIDTH.
//   - Issue rate: one word per WIDTH+2 cycles.
// - BUSY=1 in SHIFT and DONE, 0 in IDLE.
// - REQ and DATA are sampled only in IDLE.
// - REQ asserted or dropped during SHIFT/DONE has no effect.
// - A REQ still high after its ACK is treated as a new request at the next IDLE.
// - Fairness: ptr moves past each winner. With all NREQ requesting continuously, every requester is served once per NREQ grants.
// - The accumulator is 1 bit; cnt is $clog2(WIDTH) bits wide and never wraps inside a word.
// - PAR = ^DATA[w] (1 when the word has an odd number of ones).
// TESTING
// - Model XOR_Z = XOR_A1 ^ XOR_A2 in the bench for all tests.
// - Test 1: reset, then REQ=4'b0001, DATA[0]=8'hB5.
//   -> ACK=4'b0001 at T+1; PAR_VLD at T+9 with PAR=1, PAR_ID=0.
// - Test 2: REQ=4'b0010 with DATA[1]=8'h00, then 8'hFF -> PAR=0 both times; PAR_ID=1.
// - Test 3: after reset, REQ=4'b1111 held continuously.
//   -> ACK order 0,1,2,3,0; grants 10 cycles apart (WIDTH=8).
// - Test 4: ptr=2, REQ=4'b1010 -> requester 3 is granted, then requester 1.
// - Test 5: assert RST during the 4th SHIFT cycle.
//   -> no PAR_VLD, all outputs 0 the next cycle; the next REQ=4'b1000 is still granted to 3 (ptr=0 search).
// - Test 6: toggle REQ and DATA randomly while BUSY=1 -> captured word and PAR unchanged; no extra ACK.

Source files
------------

// File: rtl/xor_parity_scheduler.sv
// Round-robin scheduler that time-shares one external xor2 cell between NREQ
// requesters, folding each granted word bit-serially into its even-parity bit.
module xor_parity_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DATA,
  output logic [NREQ-1:0]       ACK,
  output logic                  BUSY,
  output logic                  PAR,
  output logic                  PAR_VLD,
  output logic [IDW-1:0]        PAR_ID,
  output logic                  XOR_A1,
  output logic                  XOR_A2,
  input  logic                  XOR_Z,
  inout  wire                   VDD,
  inout  wire                   VSS
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic              acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic              found;
  logic [IDW-1:0]    winner;
  int                idx;

  // Supplies carry no logic; tie them off so they are not flagged as dangling.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // Winner is the first pending requester at or after the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && REQ[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sreg_d  = DATA[int'(winner)*WIDTH +: WIDTH];
          acc_d   = 1'b0;
          cnt_d   = '0;
          id_d    = winner;
          ptr_d   = IDW'((int'(winner) + 1) % NREQ);
          ack_d   = NREQ'(1) << winner;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = XOR_Z;
        sreg_d = sreg_q >> 1;
        // Hold the count on the last bit so it never wraps inside a word.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sreg_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign ACK     = ack_q;
  assign BUSY    = (state_q != IDLE);
  assign PAR_VLD = (state_q == DONE);
  assign PAR     = (state_q == DONE) ? acc_q : 1'b0;
  assign PAR_ID  = (state_q == DONE) ? id_q : '0;
  assign XOR_A1  = (state_q == SHIFT) ? acc_q : 1'b0;
  assign XOR_A2  = (state_q == SHIFT) ? sreg_q[0] : 1'b0;

endmodule

// File: tb/tb_xor_parity_scheduler.sv
// Directed bench for xor_parity_scheduler; the shared xor2 cell is modelled
// here so parity results come purely from the scheduler's pin sequencing.
module tb_xor_parity_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        busy;
  logic        par;
  logic        par_vld;
  logic [1:0]  par_id;
  logic        xor_a1;
  logic        xor_a2;
  logic        xor_z;
  wire         vdd = 1'b1;
  wire         vss = 1'b0;

  int vectors;
  int miscompares;

  xor_parity_scheduler #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .DATA(data), .ACK(ack), .BUSY(busy),
    .PAR(par), .PAR_VLD(par_vld), .PAR_ID(par_id), .XOR_A1(xor_a1),
    .XOR_A2(xor_a2), .XOR_Z(xor_z), .VDD(vdd), .VSS(vss)
  );

  assign xor_z = xor_a1 ^ xor_a2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; req = '0; data = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ack, busy, par, par_vld, par_id, xor_a1, xor_a2} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {ack, busy, par, par_vld, par_id, xor_a1, xor_a2}, 11'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    logic bad;
    bad = 1'b0;
    req = 4'b0001; data[7:0] = 8'hB5;
    @(negedge clk);
    vectors++;
    if (ack !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL t1_ack: got %b expected %b", ack, 4'b0001);
    end
    vectors++;
    if ({busy, xor_a1, xor_a2} !== 3'b101) begin
      miscompares++; $display("[TB] FAIL t1_first_shift: got %b expected %b", {busy, xor_a1, xor_a2}, 3'b101);
    end
    req = '0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (par_vld !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("[TB] FAIL t1_shift_window: got bad=%b expected 0", bad);
    end
    @(negedge clk);
    vectors++;
    if ({par_vld, par, par_id} !== 4'b1100) begin
      miscompares++; $display("[TB] FAIL t1_result: got %b expected %b", {par_vld, par, par_id}, 4'b1100);
    end
    @(negedge clk);
    vectors++;
    if ({busy, par_vld} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL t1_idle: got %b expected %b", {busy, par_vld}, 2'b00);
    end
  endtask

  task automatic test_zero_and_ones();
    logic [7:0] words [2];
    words[0] = 8'h00;
    words[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      req = 4'b0010; data[15:8] = words[k];
      @(negedge clk);
      vectors++;
      if (ack !== 4'b0010) begin
        miscompares++; $display("[TB] FAIL t2_ack%0d: got %b expected %b", k, ack, 4'b0010);
      end
      req = '0;
      repeat (8) @(negedge clk);
      vectors++;
      if ({par_vld, par, par_id} !== 4'b1001) begin
        miscompares++; $display("[TB] FAIL t2_result%0d: got %b expected %b", k, {par_vld, par, par_id}, 4'b1001);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack [5];
    logic [2:0] exp_res [4];
    int n_ack, n_par, last_cyc;
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0100;
    exp_ack[3] = 4'b1000; exp_ack[4] = 4'b0001;
    exp_res[0] = {1'b1, 2'd0}; exp_res[1] = {1'b0, 2'd1};
    exp_res[2] = {1'b1, 2'd2}; exp_res[3] = {1'b0, 2'd3};
    n_ack = 0; n_par = 0; last_cyc = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    data = 32'h0F070301;
    req = 4'b1111;
    for (int cyc = 1; cyc <= 60 && n_ack < 5; cyc++) begin
      @(negedge clk);
      if (par_vld === 1'b1 && n_par < 4) begin
        vectors++;
        if ({par, par_id} !== exp_res[n_par]) begin
          miscompares++; $display("[TB] FAIL t3_par%0d: got %b expected %b", n_par, {par, par_id}, exp_res[n_par]);
        end
        n_par++;
      end
      if (ack !== 4'b0000) begin
        vectors++;
        if (ack !== exp_ack[n_ack]) begin
          miscompares++; $display("[TB] FAIL t3_order%0d: got %b expected %b", n_ack, ack, exp_ack[n_ack]);
        end
        vectors++;
        if (cyc - last_cyc !== ((n_ack == 0) ? 1 : 10)) begin
          miscompares++; $display("[TB] FAIL t3_spacing%0d: got %0d expected %0d", n_ack, cyc - last_cyc, (n_ack == 0) ? 1 : 10);
        end
        last_cyc = cyc;
        n_ack++;
      end
    end
    req = '0;
    vectors++;
    if (n_ack !== 5 || n_par !== 4) begin
      miscompares++; $display("[TB] FAIL t3_counts: got acks=%0d pars=%0d expected 5 and 4", n_ack, n_par);
    end
    repeat (9) @(negedge clk);
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] exp_ack [2];
    int n_ack;
    exp_ack[0] = 4'b1000; exp_ack[1] = 4'b0010;
    n_ack = 0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 4'b0010; data = 32'h0;
    @(negedge clk);
    vectors++;
    if (ack !== 4'b0010) begin
      miscompares++; $display("[TB] FAIL t4_setup_ack: got %b expected %b", ack, 4'b0010);
    end
    req = '0;
    repeat (9) @(negedge clk);
    req = 4'b1010;
    for (int cyc = 1; cyc <= 30 && n_ack < 2; cyc++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        vectors++;
        if (ack !== exp_ack[n_ack]) begin
          miscompares++; $display("[TB] FAIL t4_order%0d: got %b expected %b", n_ack, ack, exp_ack[n_ack]);
        end
        n_ack++;
      end
    end
    req = '0;
    vectors++;
    if (n_ack !== 2) begin
      miscompares++; $display("[TB] FAIL t4_count: got %0d expected 2", n_ack);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic bad;
    bad = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 4'b0001; data = 32'h000000B5;
    @(negedge clk);
    vectors++;
    if (ack !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL t5_ack: got %b expected %b", ack, 4'b0001);
    end
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ack, busy, par, par_vld, par_id, xor_a1, xor_a2} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL t5_abort_outputs: got %b expected %b",
               {ack, busy, par, par_vld, par_id, xor_a1, xor_a2}, 11'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (par_vld !== 1'b0 || ack !== 4'b0000) bad = 1'b1;
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("[TB] FAIL t5_no_late_result: got bad=%b expected 0", bad);
    end
    req = 4'b1001;
    @(negedge clk);
    vectors++;
    if (ack !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL t5_ptr_cleared: got %b expected %b", ack, 4'b0001);
    end
    req = '0;
    repeat (9) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    vectors++;
    if (ack !== 4'b1000) begin
      miscompares++; $display("[TB] FAIL t5_req3: got %b expected %b", ack, 4'b1000);
    end
    req = '0;
    repeat (9) @(negedge clk);
  endtask

  task automatic test_busy_toggle();
    logic bad;
    bad = 1'b0;
    req = 4'b0100; data = 32'h005B0000;
    @(negedge clk);
    vectors++;
    if (ack !== 4'b0100) begin
      miscompares++; $display("[TB] FAIL t6_ack: got %b expected %b", ack, 4'b0100);
    end
    for (int c = 2; c <= 9; c++) begin
      req  = 4'($urandom_range(15, 0));
      data = $urandom;
      @(negedge clk);
      if (ack !== 4'b0000) bad = 1'b1;
      if (c < 9 && par_vld !== 1'b0) bad = 1'b1;
    end
    req = '0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++; $display("[TB] FAIL t6_no_extra_ack: got bad=%b expected 0", bad);
    end
    vectors++;
    if ({par_vld, par, par_id} !== 4'b1110) begin
      miscompares++; $display("[TB] FAIL t6_result: got %b expected %b", {par_vld, par, par_id}, 4'b1110);
    end
    @(negedge clk);
    vectors++;
    if ({busy, ack} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL t6_idle: got %b expected %b", {busy, ack}, 5'b0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    req = '0;
    data = '0;
    test_reset();
    test_single_word();
    test_zero_and_ones();
    test_round_robin();
    test_ptr_wrap();
    test_mid_reset();
    test_busy_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
